// File: rtl/fp_align_pipe.sv
// fp_align_pipe
//   Two-stage elastic operand aligner for the IEEE-754 add/sub datapath.
//   Stage 1 classifies and sorts the operand pair by magnitude and applies the
//   effective subtract sign. Stage 2 right-shifts the smaller significand and
//   folds the shifted-out bits into a sticky LSB.
// Ports
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : operand pair handshake (in_ready has no in_valid path)
//   in_sub             : 1 = A-B, 0 = A+B
//   in_a, in_b         : operands {sign, exp, frac}
//   out_valid/out_ready: result handshake; out_* held while stalled
//   out_sa, out_sb     : sign of larger operand, effective sign of smaller
//   out_exp            : exponent of larger operand (subnormal reported as 1)
//   out_ma, out_mb     : larger significand, aligned smaller significand
//   out_swap           : |B| > |A|
//   out_cancel         : exact cancellation, result +0
//   out_bypass         : smaller operand is zero
//   out_special        : an exponent is all-ones, no shift applied
module fp_align_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int SIG_W = MAN_W + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sa,
  output logic             out_sb,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_ma,
  output logic [SIG_W-1:0] out_mb,
  output logic             out_swap,
  output logic             out_cancel,
  output logic             out_bypass,
  output logic             out_special
);

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // Handshake
  logic v1_q, v1_d, v2_q, v2_d;
  logic adv1, adv2;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Stage 1 registers
  logic             s1_sa_q, s1_sa_d, s1_sb_q, s1_sb_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s1_mv_q, s1_mv_d;
  logic [SIG_W-1:0] s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  logic             s1_swap_q, s1_swap_d, s1_cancel_q, s1_cancel_d;
  logic             s1_bypass_q, s1_bypass_d, s1_special_q, s1_special_d;

  // Stage 2 registers
  logic             s2_sa_q, s2_sa_d, s2_sb_q, s2_sb_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [SIG_W-1:0] s2_ma_q, s2_ma_d, s2_mb_q, s2_mb_d;
  logic             s2_swap_q, s2_swap_d, s2_cancel_q, s2_cancel_d;
  logic             s2_bypass_q, s2_bypass_d, s2_special_q, s2_special_d;

  // Stage 1 classification
  logic             sb_eff, swap, sgn_l, sgn_s;
  logic [W-2:0]     mag_a, mag_b, mag_l, mag_s;
  logic [EXP_W-1:0] exp_l, exp_s, eexp_l, eexp_s;
  logic             special, cancel, bypass;

  always_comb begin
    sb_eff  = in_b[W-1] ^ in_sub;
    mag_a   = in_a[W-2:0];
    mag_b   = in_b[W-2:0];
    swap    = (mag_b > mag_a);
    mag_l   = swap ? mag_b : mag_a;
    mag_s   = swap ? mag_a : mag_b;
    sgn_l   = swap ? sb_eff : in_a[W-1];
    sgn_s   = swap ? in_a[W-1] : sb_eff;
    exp_l   = mag_l[W-2:MAN_W];
    exp_s   = mag_s[W-2:MAN_W];
    eexp_l  = (exp_l == '0) ? EXP_ONE : exp_l;
    eexp_s  = (exp_s == '0) ? EXP_ONE : exp_s;
    special = (&mag_a[W-2:MAN_W]) || (&mag_b[W-2:MAN_W]);
    cancel  = !special && (mag_a == mag_b) && (in_a[W-1] != sb_eff);
    bypass  = !special && !cancel && (mag_s == '0);
  end

  always_comb begin
    v1_d         = adv1 ? in_valid : v1_q;
    s1_sa_d      = s1_sa_q;
    s1_sb_d      = s1_sb_q;
    s1_exp_d     = s1_exp_q;
    s1_mv_d      = s1_mv_q;
    s1_ma_d      = s1_ma_q;
    s1_mb_d      = s1_mb_q;
    s1_swap_d    = s1_swap_q;
    s1_cancel_d  = s1_cancel_q;
    s1_bypass_d  = s1_bypass_q;
    s1_special_d = s1_special_q;
    if (adv1 && in_valid) begin
      s1_sa_d      = sgn_l;
      s1_sb_d      = sgn_s;
      s1_exp_d     = eexp_l;
      s1_mv_d      = eexp_l - eexp_s;
      s1_ma_d      = {(exp_l != '0), mag_l[MAN_W-1:0], 3'b000};
      s1_mb_d      = {(exp_s != '0), mag_s[MAN_W-1:0], 3'b000};
      s1_swap_d    = swap;
      s1_cancel_d  = cancel;
      s1_bypass_d  = bypass;
      s1_special_d = special;
      if (special) begin
        s1_mv_d = '0;
      end else if (cancel) begin
        s1_sa_d  = 1'b0;
        s1_sb_d  = 1'b0;
        s1_exp_d = '0;
        s1_mv_d  = '0;
        s1_ma_d  = '0;
        s1_mb_d  = '0;
      end else if (bypass) begin
        s1_mv_d = '0;
        s1_mb_d = '0;
        // Both operands zero: report a true zero rather than exponent 1
        if (mag_l == '0) s1_exp_d = '0;
      end
    end
  end

  // Stage 2 alignment shift with sticky collection
  logic [SIG_W-1:0] lost_mask, mb_shift, mb_aligned;
  logic             sticky;

  always_comb begin
    lost_mask = ~({SIG_W{1'b1}} << s1_mv_q);
    mb_shift  = s1_mb_q >> s1_mv_q;
    sticky    = |(s1_mb_q & lost_mask);
    if (int'(s1_mv_q) >= SIG_W) begin
      mb_aligned = {{(SIG_W-1){1'b0}}, |s1_mb_q};
    end else begin
      mb_aligned = mb_shift | {{(SIG_W-1){1'b0}}, sticky};
    end
  end

  always_comb begin
    v2_d         = adv2 ? v1_q : v2_q;
    s2_sa_d      = s2_sa_q;
    s2_sb_d      = s2_sb_q;
    s2_exp_d     = s2_exp_q;
    s2_ma_d      = s2_ma_q;
    s2_mb_d      = s2_mb_q;
    s2_swap_d    = s2_swap_q;
    s2_cancel_d  = s2_cancel_q;
    s2_bypass_d  = s2_bypass_q;
    s2_special_d = s2_special_q;
    if (adv2 && v1_q) begin
      s2_sa_d      = s1_sa_q;
      s2_sb_d      = s1_sb_q;
      s2_exp_d     = s1_exp_q;
      s2_ma_d      = s1_ma_q;
      s2_mb_d      = mb_aligned;
      s2_swap_d    = s1_swap_q;
      s2_cancel_d  = s1_cancel_q;
      s2_bypass_d  = s1_bypass_q;
      s2_special_d = s1_special_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      s1_sa_q      <= 1'b0;
      s1_sb_q      <= 1'b0;
      s1_exp_q     <= '0;
      s1_mv_q      <= '0;
      s1_ma_q      <= '0;
      s1_mb_q      <= '0;
      s1_swap_q    <= 1'b0;
      s1_cancel_q  <= 1'b0;
      s1_bypass_q  <= 1'b0;
      s1_special_q <= 1'b0;
      s2_sa_q      <= 1'b0;
      s2_sb_q      <= 1'b0;
      s2_exp_q     <= '0;
      s2_ma_q      <= '0;
      s2_mb_q      <= '0;
      s2_swap_q    <= 1'b0;
      s2_cancel_q  <= 1'b0;
      s2_bypass_q  <= 1'b0;
      s2_special_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      s1_sa_q      <= s1_sa_d;
      s1_sb_q      <= s1_sb_d;
      s1_exp_q     <= s1_exp_d;
      s1_mv_q      <= s1_mv_d;
      s1_ma_q      <= s1_ma_d;
      s1_mb_q      <= s1_mb_d;
      s1_swap_q    <= s1_swap_d;
      s1_cancel_q  <= s1_cancel_d;
      s1_bypass_q  <= s1_bypass_d;
      s1_special_q <= s1_special_d;
      s2_sa_q      <= s2_sa_d;
      s2_sb_q      <= s2_sb_d;
      s2_exp_q     <= s2_exp_d;
      s2_ma_q      <= s2_ma_d;
      s2_mb_q      <= s2_mb_d;
      s2_swap_q    <= s2_swap_d;
      s2_cancel_q  <= s2_cancel_d;
      s2_bypass_q  <= s2_bypass_d;
      s2_special_q <= s2_special_d;
    end
  end

  assign out_valid   = v2_q;
  assign out_sa      = s2_sa_q;
  assign out_sb      = s2_sb_q;
  assign out_exp     = s2_exp_q;
  assign out_ma      = s2_ma_q;
  assign out_mb      = s2_mb_q;
  assign out_swap    = s2_swap_q;
  assign out_cancel  = s2_cancel_q;
  assign out_bypass  = s2_bypass_q;
  assign out_special = s2_special_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe
//   Directed-vector bench for fp_align_pipe at binary16 defaults.
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic        out_sa, out_sb;
  logic [4:0]  out_exp;
  logic [13:0] out_ma, out_mb;
  logic        out_swap, out_cancel, out_bypass, out_special;

  int n_checks = 0;
  int n_errors = 0;

  fp_align_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sa(out_sa), .out_sb(out_sb), .out_exp(out_exp),
    .out_ma(out_ma), .out_mb(out_mb), .out_swap(out_swap),
    .out_cancel(out_cancel), .out_bypass(out_bypass), .out_special(out_special)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one pair with out_ready high and check the 2-cycle latency.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    #1 chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".lat2"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic sa, input logic sb,
                            input logic [4:0] e, input logic [13:0] ma,
                            input logic [13:0] mb, input logic swp, input logic can,
                            input logic byp, input logic spc);
    chk({tag, ".sa"},      32'(out_sa),      32'(sa));
    chk({tag, ".sb"},      32'(out_sb),      32'(sb));
    chk({tag, ".exp"},     32'(out_exp),     32'(e));
    chk({tag, ".ma"},      32'(out_ma),      32'(ma));
    chk({tag, ".mb"},      32'(out_mb),      32'(mb));
    chk({tag, ".swap"},    32'(out_swap),    32'(swp));
    chk({tag, ".cancel"},  32'(out_cancel),  32'(can));
    chk({tag, ".bypass"},  32'(out_bypass),  32'(byp));
    chk({tag, ".special"}, 32'(out_special), 32'(spc));
  endtask

  logic [15:0] st_a   [4] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
  logic [4:0]  st_exp [4] = '{5'h0F, 5'h10, 5'h11, 5'h12};
  logic [13:0] st_mb  [4] = '{14'h1000, 14'h0800, 14'h0400, 14'h0200};

  initial begin
    int in_idx, out_idx;
    logic in_fire;
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.ma", 32'(out_ma), 32'd0);
    chk("rst.mb", 32'(out_mb), 32'd0);

    apply("add", 16'h3C00, 16'h3800, 1'b0);
    expect_out("add", 0, 0, 5'h0F, 14'h2000, 14'h1000, 0, 0, 0, 0);
    apply("subswap", 16'h3800, 16'h3C00, 1'b1);
    expect_out("subswap", 1, 0, 5'h0F, 14'h2000, 14'h1000, 1, 0, 0, 0);
    apply("cancel", 16'h3C00, 16'h3C00, 1'b1);
    expect_out("cancel", 0, 0, 5'h00, 14'h0000, 14'h0000, 0, 1, 0, 0);
    apply("mv14", 16'h3C01, 16'h0401, 1'b0);
    expect_out("mv14", 0, 0, 5'h0F, 14'h2008, 14'h0001, 0, 0, 0, 0);
    apply("special", 16'h7C00, 16'h0401, 1'b0);
    expect_out("special", 0, 0, 5'h1F, 14'h2000, 14'h2008, 0, 0, 0, 1);
    apply("bypass", 16'h0000, 16'hC200, 1'b0);
    expect_out("bypass", 1, 0, 5'h10, 14'h3000, 14'h0000, 1, 0, 1, 0);
    apply("zeros", 16'h8000, 16'h0000, 1'b1);
    expect_out("zeros", 1, 1, 5'h00, 14'h0000, 14'h0000, 0, 0, 1, 0);
    apply("subn", 16'h0010, 16'h0001, 1'b0);
    expect_out("subn", 0, 0, 5'h01, 14'h0080, 14'h0008, 0, 0, 0, 0);
    apply("sticky", 16'h5400, 16'h3C07, 1'b0);
    expect_out("sticky", 0, 0, 5'h15, 14'h2000, 14'h0081, 0, 0, 0, 0);

    // Back-to-back pushes into a stalled output
    @(negedge clk);
    repeat (2) @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_sub = 1'b0; in_b = 16'h3800; in_a = st_a[0];
    #1 chk("stall.rdy0", 32'(in_ready), 32'd1);
    @(negedge clk); in_a = st_a[1];
    #1 chk("stall.rdy1", 32'(in_ready), 32'd1);
    @(negedge clk); in_a = st_a[2];
    #1 chk("stall.rdy2", 32'(in_ready), 32'd0);
    chk("stall.valid", 32'(out_valid), 32'd1);
    chk("stall.exp_a", 32'(out_exp), 32'(st_exp[0]));
    @(negedge clk);
    #1 chk("stall.rdy3", 32'(in_ready), 32'd0);
    chk("stall.exp_b", 32'(out_exp), 32'(st_exp[0]));
    chk("stall.mb_b", 32'(out_mb), 32'(st_mb[0]));
    out_ready = 1'b1;
    in_idx = 2; out_idx = 0;
    for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("drain%0d.exp", out_idx), 32'(out_exp), 32'(st_exp[out_idx]));
        chk($sformatf("drain%0d.mb", out_idx), 32'(out_mb), 32'(st_mb[out_idx]));
        out_idx++;
      end
      in_fire = in_valid && in_ready;
      @(negedge clk);
      if (in_fire) in_idx++;
      if (in_idx < 4) in_a = st_a[in_idx];
      else in_valid = 1'b0;
    end
    chk("drain.count", 32'(out_idx), 32'd4);

    // Reset with both stages occupied
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3800;
    @(negedge clk); in_a = 16'h4000;
    @(negedge clk); in_valid = 1'b0;
    chk("full.valid", 32'(out_valid), 32'd1);
    chk("full.ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.ready", 32'(in_ready), 32'd1);
    chk("midrst.exp", 32'(out_exp), 32'd0);
    chk("midrst.ma", 32'(out_ma), 32'd0);
    chk("midrst.mb", 32'(out_mb), 32'd0);
    @(negedge clk);
    chk("midrst.valid2", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst.valid3", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
